// File: rtl/divider_4bit_seq_if.sv
// Bus for the sequential divider: request, operands, results and debug taps.
// Handshake: start is accepted on any clock edge where the divider is idle
// and start=1. Operands are captured at that edge. done pulses for one cycle
// when results are valid. Results stay put until the next accepted start.
interface divider_4bit_seq_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] state_dbg;
  logic [3:0] r_dbg;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state_dbg, r_dbg
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state_dbg, r_dbg
  );
endinterface

// File: rtl/divider_4bit_seq.sv
// 4-bit unsigned restoring divider: one trial subtraction per cycle through a
// shared 4-bit subtracter, MSB-first quotient, start/done handshake.
module subtracter_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       sign
);
  // Magnitude of the difference; sign flags a < b.
  assign sign = (a < b);
  assign s    = sign ? (b - a) : (a - b);
endmodule

module divider_4bit_seq (
  input logic               clk,
  input logic               reset,
  divider_4bit_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] a_sh;
  logic [3:0] d_reg;
  logic [3:0] r;
  logic [2:0] q;
  logic [1:0] cnt;

  logic [3:0] t;
  logic [3:0] s;
  logic       sign;
  logic [3:0] r_next;
  logic       q_bit;

  // r[3] is always 0 entering a RUN cycle, so the 4-bit trial value is enough.
  assign t      = {r[2:0], a_sh[3]};
  assign r_next = sign ? t : s;
  assign q_bit  = ~sign;

  subtracter_4bit u_sub (
    .a    (t),
    .b    (d_reg),
    .s    (s),
    .sign (sign)
  );

  assign bus.state_dbg = state;
  assign bus.r_dbg     = r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      a_sh            <= 4'h0;
      d_reg           <= 4'h0;
      r               <= 4'h0;
      q               <= 3'h0;
      cnt             <= 2'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= 4'h0;
      bus.remainder   <= 4'h0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.divisor != 4'h0) begin
              a_sh  <= bus.dividend;
              d_reg <= bus.divisor;
              r     <= 4'h0;
              q     <= 3'h0;
              cnt   <= 2'd0;
              state <= RUN;
            end else begin
              // Divide by zero skips the iterations entirely.
              bus.quotient    <= 4'hF;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end
          end
        end
        RUN: begin
          r    <= r_next;
          q    <= {q[1:0], q_bit};
          a_sh <= {a_sh[2:0], 1'b0};
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            bus.quotient    <= {q, q_bit};
            bus.remainder   <= r_next;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
